memory_arbiter_wrr: RTL
=======================

MEMORY_ARBITER_WRR -- requirements
Module: memory_arbiter_wrr

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 25: RAM word address width.
REQ-002 Parameter DATA_WIDTH, default 8: RAM data width.
REQ-003 Parameter PERIPHERALS, default 3: channel count; legal range 1..16.
REQ-004 Parameter FIFO_DEPTH, default 16: per-channel request FIFO depth; power of two, at least 2.
REQ-005 Parameter MAX_BURST, default 4: maximum consecutive grants to one channel; at least 1.
REQ-006 Parameter RAM_LATENCY, default 2: cycles from ram_en high to valid ram_q; at least 1.
REQ-007 One clock, clk; reset is synchronous and active-low, reset_n.
REQ-008 clk  in  1  sole clock; all state changes on the rising edge.
REQ-009 reset_n  in  1  synchronous active-low reset.
REQ-010 req_address  in  ADDRESS_WIDTH*PERIPHERALS  per-channel address; channel k occupies bits [(k+1)*ADDRESS_WIDTH-1 : k*ADDRESS_WIDTH].
REQ-011 req_data  in  DATA_WIDTH*PERIPHERALS  per-channel write data, packed the same way.
REQ-012 req_wr  in  PERIPHERALS  1 = write, 0 = read, per channel.
REQ-013 req_valid  in  PERIPHERALS  per-channel request strobe.
REQ-014 req_ready  out  PERIPHERALS  per-channel FIFO not full.
REQ-015 rsp_data  out  DATA_WIDTH  read data, shared by all channels.
REQ-016 rsp_valid  out  PERIPHERALS  one-hot pulse identifying the owner of rsp_data.
REQ-017 ram_en, ram_wren  out  1 each  RAM access strobe and write enable.
REQ-018 ram_address  out  ADDRESS_WIDTH  RAM address; ram_data  out  DATA_WIDTH  RAM write data.
REQ-019 ram_q  in  DATA_WIDTH  RAM read data, valid RAM_LATENCY cycles after ram_en.

Function
REQ-020 Channel k request accepted on a rising edge where req_valid[k] && req_ready[k]; address, data and wr are stored together.
REQ-021 req_ready[k] = (count[k] < FIFO_DEPTH), combinational from registered count; a push is refused when full even if a pop occurs in the same cycle.
REQ-022 Per-channel count is clog2(FIFO_DEPTH)+1 bits; read and write pointers wrap from FIFO_DEPTH-1 to 0; simultaneous push and pop leaves count unchanged.
REQ-023 Arbiter issues at most one FIFO pop per cycle, and only from a non-empty FIFO.
REQ-024 Arbiter has two states, IDLE and GRANT, plus current-channel pointer cur and burst counter bc.
REQ-025 IDLE: if any FIFO is non-empty, select the first non-empty channel in round-robin order starting at cur+1 mod PERIPHERALS, pop it in the same cycle, set bc=1, go to GRANT; otherwise stay in IDLE.
REQ-026 GRANT: if cur is non-empty and bc < MAX_BURST, pop cur and increment bc.
REQ-027 GRANT: otherwise, switch in the same cycle, with no bubble, to the next non-empty channel from cur+1 and set bc=1; if all FIFOs are empty, go to IDLE.
REQ-028 When cur is the only non-empty channel and bc reaches MAX_BURST, cur is granted again with bc=1.
REQ-029 A pop in cycle T drives ram_en=1, ram_wren, ram_address and ram_data as registered outputs valid after edge T; cycles without a pop drive ram_en=0 and ram_wren=0, and ram_address/ram_data hold their values.
REQ-030 Minimum latency: a request accepted at edge E0 into an empty system appears on ram_* after edge E0+1.
REQ-031 Each read issue pushes a one-hot channel tag into a RAM_LATENCY-stage shift register; write issues push zero.
REQ-032 When the tag emerges, rsp_data is registered from ram_q, and rsp_valid equals the tag for exactly one cycle, RAM_LATENCY+1 cycles after ram_en.
REQ-033 Responses return in issue order; there is no backpressure on rsp.
REQ-034 rsp_valid has at most one bit high per cycle.

Reset
REQ-035 While reset_n=0 at a rising edge: all counts and pointers=0, cur=PERIPHERALS-1 (so channel 0 is searched first), bc=0, state=IDLE, tag pipeline cleared.
REQ-036 While reset_n=0 at a rising edge: ram_en=0, ram_wren=0, ram_address=0, ram_data=0, rsp_valid=0, rsp_data=0; req_ready is all ones after the reset edge.
REQ-037 Reset asserted mid-operation discards all queued and in-flight requests; no rsp_valid pulse occurs for them after reset.

Verification
REQ-038 Single write ch0 addr 0x10 data 0xA5, then read ch0 addr 0x10 -> ram_en/ram_wren=1 one cycle after accept; rsp_valid=3'b001, rsp_data=0xA5 RAM_LATENCY+1 cycles after the read issue.
REQ-039 Fill ch1 with 16 requests while the arbiter is held off by preloaded traffic -> req_ready[1]=0 at count 16; a 17th push is dropped; pointer wraps correctly on drain.
REQ-040 All 3 channels preloaded with 8 reads each, MAX_BURST=4 -> issue order is ch0x4, ch1x4, ch2x4, repeated; ram_en continuously high for 24 cycles.
REQ-041 Only ch2 active with 10 requests -> ten back-to-back issues from ch2, no bubble at the burst boundary.
REQ-042 Reset pulse 2 cycles after 3 reads issued -> no rsp_valid afterwards; all outputs at reset values; req_ready=3'b111.
REQ-043 Parameter sweep with PERIPHERALS=1, FIFO_DEPTH=2, RAM_LATENCY=1 -> REQ-038 and REQ-039 behaviour holds.

Source files
------------

// File: rtl/memory_arbiter_wrr.sv
`default_nettype none
// ============================================================================
// Module : memory_arbiter_wrr
// Brief  : Multi-channel request FIFOs feeding a single RAM port through a
//          weighted round-robin arbiter (bounded bursts per channel), with a
//          tag pipeline that routes read data back to the issuing channel.
// Rev    : 1.0  initial release
// ============================================================================
module memory_arbiter_wrr #(
  parameter int ADDRESS_WIDTH = 25,
  parameter int DATA_WIDTH    = 8,
  parameter int PERIPHERALS   = 3,
  parameter int FIFO_DEPTH    = 16,
  parameter int MAX_BURST     = 4,
  parameter int RAM_LATENCY   = 2
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [ADDRESS_WIDTH*PERIPHERALS-1:0] req_address,
  input  logic [DATA_WIDTH*PERIPHERALS-1:0]    req_data,
  input  logic [PERIPHERALS-1:0]               req_wr,
  input  logic [PERIPHERALS-1:0]               req_valid,
  output logic [PERIPHERALS-1:0]               req_ready,
  output logic [DATA_WIDTH-1:0]                rsp_data,
  output logic [PERIPHERALS-1:0]               rsp_valid,
  output logic                                 ram_en,
  output logic                                 ram_wren,
  output logic [ADDRESS_WIDTH-1:0]             ram_address,
  output logic [DATA_WIDTH-1:0]                ram_data,
  input  logic [DATA_WIDTH-1:0]                ram_q
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int CH_W    = (PERIPHERALS > 1) ? $clog2(PERIPHERALS) : 1;
  localparam int BC_W    = $clog2(MAX_BURST + 1);
  localparam int ENTRY_W = ADDRESS_WIDTH + DATA_WIDTH + 1;

  localparam logic [CNT_W-1:0] C_DEPTH     = CNT_W'(FIFO_DEPTH);
  localparam logic [BC_W-1:0]  C_MAX_BURST = BC_W'(MAX_BURST);
  localparam logic [CH_W-1:0]  C_LAST_CH   = CH_W'(PERIPHERALS - 1);
  localparam logic [CH_W:0]    C_NUM_CH    = (CH_W + 1)'(PERIPHERALS);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Per-channel FIFO interface to the arbiter
  logic [ENTRY_W-1:0]     fifo_head [PERIPHERALS];
  logic [PERIPHERALS-1:0] non_empty;
  logic [PERIPHERALS-1:0] push;
  logic [PERIPHERALS-1:0] pop_vec;

  // Arbiter state
  state_t          state_q, state_d;
  logic [CH_W-1:0] cur_q, cur_d;
  logic [BC_W-1:0] bc_q, bc_d;
  logic            pop_en;
  logic [CH_W-1:0] pop_ch;
  logic            found;
  logic [CH_W-1:0] next_ch;
  logic [CH_W:0]   cand;
  logic [ENTRY_W-1:0] sel_entry;

  // RAM-side and response registers
  logic                     ram_en_q, ram_en_d;
  logic                     ram_wren_q, ram_wren_d;
  logic [ADDRESS_WIDTH-1:0] ram_address_q, ram_address_d;
  logic [DATA_WIDTH-1:0]    ram_data_q, ram_data_d;
  logic [PERIPHERALS-1:0]   issue_tag_q, issue_tag_d;
  logic [PERIPHERALS-1:0]   tag_q [RAM_LATENCY];
  logic [PERIPHERALS-1:0]   tag_d [RAM_LATENCY];
  logic [PERIPHERALS-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;

  generate
    for (genvar k = 0; k < PERIPHERALS; k++) begin : g_fifo
      logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
      logic [PTR_W-1:0]   wptr_q, wptr_d;
      logic [PTR_W-1:0]   rptr_q, rptr_d;
      logic [CNT_W-1:0]   count_q, count_d;

      // Ready looks only at the registered count, so a full FIFO refuses a
      // push even in a cycle where it is also being popped.
      assign req_ready[k] = (count_q < C_DEPTH);
      assign push[k]      = req_valid[k] & req_ready[k];
      assign non_empty[k] = (count_q != '0);
      assign fifo_head[k] = mem_q[rptr_q];

      // Pointer and occupancy update; pointers wrap since depth is a power of two
      always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push[k]) begin
          wptr_d = wptr_q + 1'b1;
        end
        if (pop_vec[k]) begin
          rptr_d = rptr_q + 1'b1;
        end
        case ({push[k], pop_vec[k]})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
      end

      // FIFO control registers
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          wptr_q  <= '0;
          rptr_q  <= '0;
          count_q <= '0;
        end else begin
          wptr_q  <= wptr_d;
          rptr_q  <= rptr_d;
          count_q <= count_d;
        end
      end

      // FIFO storage: {wr, address, data} captured together on accept
      always_ff @(posedge clk) begin
        if (push[k]) begin
          mem_q[wptr_q] <= {req_wr[k],
                            req_address[k*ADDRESS_WIDTH +: ADDRESS_WIDTH],
                            req_data[k*DATA_WIDTH +: DATA_WIDTH]};
        end
      end
    end
  endgenerate

  // Round-robin search for the first non-empty channel after cur; cur itself
  // is the last candidate so a lone busy channel is re-granted.
  always_comb begin
    found   = 1'b0;
    next_ch = cur_q;
    cand    = '0;
    for (int i = 1; i <= PERIPHERALS; i++) begin
      cand = {1'b0, cur_q} + (CH_W + 1)'(i);
      if (cand >= C_NUM_CH) begin
        cand = cand - C_NUM_CH;
      end
      if (!found && non_empty[cand[CH_W-1:0]]) begin
        found   = 1'b1;
        next_ch = cand[CH_W-1:0];
      end
    end
  end

  // Arbiter next state: continue the burst on cur, else switch with no bubble
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    bc_d    = bc_q;
    pop_en  = 1'b0;
    pop_ch  = cur_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          pop_en  = 1'b1;
          pop_ch  = next_ch;
          cur_d   = next_ch;
          bc_d    = BC_W'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (non_empty[cur_q] && (bc_q < C_MAX_BURST)) begin
          pop_en = 1'b1;
          bc_d   = bc_q + 1'b1;
        end else if (found) begin
          pop_en = 1'b1;
          pop_ch = next_ch;
          cur_d  = next_ch;
          bc_d   = BC_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One-hot pop strobe back to the FIFOs
  always_comb begin
    pop_vec = '0;
    if (pop_en) begin
      pop_vec[pop_ch] = 1'b1;
    end
  end

  assign sel_entry = fifo_head[pop_ch];

  // RAM command and response routing; address/data hold when nothing issues
  always_comb begin
    ram_en_d      = pop_en;
    ram_wren_d    = pop_en & sel_entry[ENTRY_W-1];
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    issue_tag_d   = '0;
    if (pop_en) begin
      ram_address_d = sel_entry[ENTRY_W-2:DATA_WIDTH];
      ram_data_d    = sel_entry[DATA_WIDTH-1:0];
      if (!sel_entry[ENTRY_W-1]) begin
        issue_tag_d = pop_vec;
      end
    end
    tag_d[0] = issue_tag_q;
    for (int i = 1; i < RAM_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    rsp_valid_d = tag_q[RAM_LATENCY-1];
    rsp_data_d  = rsp_data_q;
    if (tag_q[RAM_LATENCY-1] != '0) begin
      rsp_data_d = ram_q;
    end
  end

  // Arbiter, RAM-side and response registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cur_q         <= C_LAST_CH;
      bc_q          <= '0;
      ram_en_q      <= 1'b0;
      ram_wren_q    <= 1'b0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      issue_tag_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      bc_q          <= bc_d;
      ram_en_q      <= ram_en_d;
      ram_wren_q    <= ram_wren_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      issue_tag_q   <= issue_tag_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      tag_q         <= tag_d;
    end
  end

  assign ram_en      = ram_en_q;
  assign ram_wren    = ram_wren_q;
  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;

endmodule
`default_nettype wire
